instr_reader: RTL and testbench
===============================

INSTR_READER -- requirements
Module: instr_reader

Interface
REQ-001 The module SHALL have parameter CNT_W, default 6, width of the burst-length input (max burst 32).
REQ-002 The module SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-003 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have port start  input  1  one-cycle burst request.
REQ-005 The module SHALL have port first_ptr  input  address_t (5)  first register index to read.
REQ-006 The module SHALL have port count  input  CNT_W  number of entries to read (0..32).
REQ-007 The module SHALL have port read_pointer  output  address_t (5)  index driven to the instruction register.
REQ-008 The module SHALL have port instruction_word  input  instruction_t  combinational read data for read_pointer, valid the same cycle.
REQ-009 The module SHALL have port out_valid  input/out_ready  output/input  1 each  valid/ready handshake toward the consumer.
REQ-010 The module SHALL have port out_word  output  instruction_t  captured entry (opcode, operand_a, operand_b, result).
REQ-011 The module SHALL have port out_index  output  5  register index of out_word.
REQ-012 The module SHALL have port out_mismatch  output  1  stored result differs from recomputed result.
REQ-013 The module SHALL have ports busy (1), done (1, one-cycle pulse) and mismatch_count (16), all outputs.
REQ-014 The module SHALL use instr_register_pkg types: operand_t 32-bit signed, result_t 64-bit signed, address_t 5-bit.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, HOLD, FINISH.
REQ-016 In IDLE, start=1 with count>0 SHALL latch ptr=first_ptr, remaining=count, and go to FETCH; busy=1 from the next cycle.
REQ-017 In IDLE, start=1 with count=0 SHALL go directly to FINISH, without asserting out_valid.
REQ-018 start while busy=1 SHALL be ignored.
REQ-019 read_pointer SHALL equal ptr in every state.
REQ-020 In FETCH, the edge SHALL capture instruction_word, ptr, and the mismatch result into the output registers, set out_valid=1, decrement remaining, increment ptr modulo 32 (31->0 wrap), and go to HOLD.
REQ-021 In HOLD with out_valid=1 and out_ready=0, all out_* outputs SHALL be held stable.
REQ-022 In HOLD with out_ready=1 and remaining>0, the next entry SHALL be captured on the same edge, giving zero bubbles and a throughput of one word per cycle.
REQ-023 In HOLD with out_ready=1 and remaining=0, the module SHALL clear out_valid and go to FINISH.
REQ-024 In FINISH, the module SHALL assert done=1 for one cycle, set busy=0, and return to IDLE.
REQ-025 Latency: first out_valid SHALL be asserted 2 cycles after the start edge.
REQ-026 out_valid SHALL NOT deassert without a completed handshake.
REQ-027 The recomputed result SHALL be defined per opcode, with ext_x the 64-bit sign extension of operand x:
- ZERO: 0
- PASSA: ext_a
- PASSB: ext_b
- ADD: ext_a+ext_b
- SUB: ext_a-ext_b
- MULT: 64-bit signed a*b
- DIV: sign-extended 32-bit signed quotient, truncated toward zero
- MOD: sign-extended 32-bit signed remainder
REQ-028 For DIV/MOD with operand_b=0, out_mismatch SHALL be 0 and no compare SHALL be made.
REQ-029 out_mismatch SHALL be 1 when the stored result differs from the recomputed result.
REQ-030 mismatch_count SHALL increment once per accepted handshake with out_mismatch=1, SHALL saturate at 16'hFFFF, and SHALL be cleared only by reset.
REQ-031 A burst crossing index 31 SHALL wrap to 0; count=32 from any first_ptr SHALL read each index exactly once.

Reset
REQ-032 While reset=1, the module SHALL force state=IDLE, out_valid=0, busy=0, done=0, out_word=0, out_index=0, out_mismatch=0, mismatch_count=0, read_pointer=0, remaining=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst with no done pulse; start SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-034 The bench SHALL cover: first_ptr=4, count=3, out_ready=1 -> out_index 4,5,6 on consecutive cycles, first out_valid 2 cycles after start, done 1 cycle after the last handshake.
REQ-035 The bench SHALL cover: first_ptr=30, count=4 -> out_index 30,31,0,1.
REQ-036 The bench SHALL cover: out_ready=0 for 5 cycles mid-burst -> out_word and out_index stable, read_pointer unchanged, no entry lost or duplicated.
REQ-037 The bench SHALL cover: an entry with ADD, a=-1, b=1, result=0 -> out_mismatch=0; the same entry with result=5 -> out_mismatch=1, mismatch_count=1.
REQ-038 The bench SHALL cover: DIV with b=0 -> out_mismatch=0; count=0 -> done pulse with no out_valid; start during busy -> ignored.
REQ-039 The bench SHALL cover: reset asserted while out_valid=1 -> out_valid=0 asynchronously, no done; a new start is accepted after release.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: opcodes, operands, results,
// register addresses and the packed instruction entry.
package instr_register_pkg;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [31:0] operand_t;
   typedef logic signed [63:0] result_t;
   typedef logic        [4:0]  address_t;

   typedef struct packed {
      opcode_t  opcode;
      operand_t operand_a;
      operand_t operand_b;
      result_t  result;
   } instruction_t;

endpackage

// File: rtl/instr_reader.sv
// Burst reader for the 32-entry instruction register. Streams entries from
// first_ptr (wrapping 31->0) over a valid/ready port, recomputes each result
// from its opcode and operands, flags disagreements and counts them.
module instr_reader
   import instr_register_pkg::*;
#(
   parameter int CNT_W = 6
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  address_t         first_ptr,
   input  logic [CNT_W-1:0] count,
   output address_t         read_pointer,
   input  instruction_t     instruction_word,
   output logic             out_valid,
   input  logic             out_ready,
   output instruction_t     out_word,
   output address_t         out_index,
   output logic             out_mismatch,
   output logic             busy,
   output logic             done,
   output logic [15:0]      mismatch_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t           state_r,     state_s;
   address_t         ptr_r,       ptr_s;
   logic [CNT_W-1:0] remaining_r, remaining_s;
   logic             valid_r,     valid_s;
   instruction_t     word_r,      word_s;
   address_t         index_r,     index_s;
   logic             mism_r,      mism_s;
   logic             busy_r,      busy_s;
   logic             done_r,      done_s;
   logic [15:0]      mcount_r,    mcount_s;
   logic             capture_s;

   // Recompute the expected result of an entry and report whether the stored
   // result disagrees. Division by zero is never judged. Quotient/remainder
   // are formed on sign-extended 64-bit operands so the most-negative / -1
   // case is well defined before truncation back to 32 bits.
   function automatic logic result_differs(input instruction_t w);
      logic signed [63:0] ext_a;
      logic signed [63:0] ext_b;
      logic signed [63:0] calc;
      logic               judge;
      ext_a = {{32{w.operand_a[31]}}, w.operand_a};
      ext_b = {{32{w.operand_b[31]}}, w.operand_b};
      calc  = 64'sd0;
      judge = 1'b1;
      case (w.opcode)
         ZERO:    calc = 64'sd0;
         PASSA:   calc = ext_a;
         PASSB:   calc = ext_b;
         ADD:     calc = ext_a + ext_b;
         SUB:     calc = ext_a - ext_b;
         MULT:    calc = ext_a * ext_b;
         DIV: begin
            if (ext_b == 64'sd0) begin
               judge = 1'b0;
            end else begin
               calc = ext_a / ext_b;
               calc = {{32{calc[31]}}, calc[31:0]};
            end
         end
         MOD: begin
            if (ext_b == 64'sd0) begin
               judge = 1'b0;
            end else begin
               calc = ext_a % ext_b;
               calc = {{32{calc[31]}}, calc[31:0]};
            end
         end
         default: calc = 64'sd0;
      endcase
      return judge && (w.result != calc);
   endfunction

   // Next-state and next-output computation for the burst sequencer.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      remaining_s = remaining_r;
      valid_s     = valid_r;
      word_s      = word_r;
      index_s     = index_r;
      mism_s      = mism_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      mcount_s    = mcount_r;
      capture_s   = 1'b0;

      case (state_r)
         IDLE: begin
            busy_s = 1'b0;
            if (start) begin
               busy_s = 1'b1;
               if (count != {CNT_W{1'b0}}) begin
                  ptr_s       = first_ptr;
                  remaining_s = count;
                  state_s     = FETCH;
               end else begin
                  done_s  = 1'b1;
                  state_s = FINISH;
               end
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            capture_s = 1'b1;
            state_s   = HOLD;
         end
         HOLD: begin
            // out_valid is always high here, so out_ready completes a handshake
            if (out_ready) begin
               if (mism_r && (mcount_r != 16'hFFFF)) begin
                  mcount_s = mcount_r + 16'd1;
               end else begin
                  mcount_s = mcount_r;
               end
               if (remaining_r != {CNT_W{1'b0}}) begin
                  capture_s = 1'b1;
               end else begin
                  valid_s = 1'b0;
                  done_s  = 1'b1;
                  state_s = FINISH;
               end
            end else begin
               state_s = HOLD;
            end
         end
         FINISH: begin
            busy_s  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            valid_s = 1'b0;
            state_s = IDLE;
         end
      endcase

      if (capture_s) begin
         word_s      = instruction_word;
         index_s     = ptr_r;
         mism_s      = result_differs(instruction_word);
         valid_s     = 1'b1;
         remaining_s = remaining_r - CNT_W'(1'b1);
         ptr_s       = ptr_r + 5'd1;
      end else begin
         word_s = word_s;
      end
   end

   // State and output registers; reset aborts any burst without a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         ptr_r       <= 5'd0;
         remaining_r <= {CNT_W{1'b0}};
         valid_r     <= 1'b0;
         word_r      <= '0;
         index_r     <= 5'd0;
         mism_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         mcount_r    <= 16'd0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         remaining_r <= remaining_s;
         valid_r     <= valid_s;
         word_r      <= word_s;
         index_r     <= index_s;
         mism_r      <= mism_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         mcount_r    <= mcount_s;
      end
   end

   assign read_pointer   = ptr_r;
   assign out_valid      = valid_r;
   assign out_word       = word_r;
   assign out_index      = index_r;
   assign out_mismatch   = mism_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign mismatch_count = mcount_r;

endmodule

// File: tb/tb_instr_reader.sv
// Self-checking bench for instr_reader: random register contents, a
// reference model built from the opcode rules, and directed burst scenarios.
module tb_instr_reader;
   import instr_register_pkg::*;

   localparam int CNT_W = 6;

   logic             clk;
   logic             reset;
   logic             start;
   address_t         first_ptr;
   logic [CNT_W-1:0] count;
   address_t         read_pointer;
   instruction_t     instruction_word;
   logic             out_valid;
   logic             out_ready;
   instruction_t     out_word;
   address_t         out_index;
   logic             out_mismatch;
   logic             busy;
   logic             done;
   logic [15:0]      mismatch_count;

   instruction_t mem [32];
   int checks;
   int passes;
   int fails;
   int exp_mc;

   instr_reader #(.CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .first_ptr        (first_ptr),
      .count            (count),
      .read_pointer     (read_pointer),
      .instruction_word (instruction_word),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_word         (out_word),
      .out_index        (out_index),
      .out_mismatch     (out_mismatch),
      .busy             (busy),
      .done             (done),
      .mismatch_count   (mismatch_count)
   );

   // Combinational register file model feeding the reader.
   assign instruction_word = mem[read_pointer];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result from the opcode rules using plain integer arithmetic.
   function automatic longint model_result(input instruction_t w);
      longint a;
      longint b;
      a = longint'($signed(w.operand_a));
      b = longint'($signed(w.operand_b));
      case (w.opcode)
         ZERO:    return 0;
         PASSA:   return a;
         PASSB:   return b;
         ADD:     return a + b;
         SUB:     return a - b;
         MULT:    return a * b;
         DIV:     return (b == 0) ? 0 : longint'(int'(a / b));
         MOD:     return (b == 0) ? 0 : longint'(int'(a % b));
         default: return 0;
      endcase
   endfunction

   function automatic bit model_mism(input instruction_t w);
      if ((w.opcode == DIV || w.opcode == MOD) && w.operand_b == 0) return 1'b0;
      return longint'(w.result) != model_result(w);
   endfunction

   function automatic instruction_t rand_entry();
      instruction_t w;
      logic [3:0] op;
      op = 4'($urandom_range(0, 7));
      w.opcode    = opcode_t'(op);
      w.operand_a = $urandom;
      w.operand_b = ($urandom_range(0, 3) == 0) ? 32'sd0 : $urandom;
      w.result    = model_result(w);
      if (model_mism(w) == 1'b0 && (w.opcode == DIV || w.opcode == MOD) && w.operand_b == 0)
         w.result = {$urandom, $urandom};
      return w;
   endfunction

   task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one burst starting at the current negedge. mode 0: always ready,
   // 1: random ready, 2: 5-cycle stall on the second word plus a start while busy.
   task automatic burst(input int fp, input int cnt, input int mode);
      int q_idx[$];
      int cyc;
      int idx;
      bit rdy;
      for (int i = 0; i < cnt; i++) q_idx.push_back((fp + i) % 32);
      start     = 1'b1;
      first_ptr = 5'(fp);
      count     = CNT_W'(cnt);
      out_ready = 1'b1;
      chk("valid_before_start", out_valid, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      chk("valid_not_early", out_valid, 1'b0);
      if (cnt == 0) begin
         chk("zero_done", done, 1'b1);
         @(negedge clk);
         chk("zero_no_valid", out_valid, 1'b0);
         chk("zero_done_once", done, 1'b0);
         chk("zero_idle", busy, 1'b0);
         return;
      end
      chk("no_done_early", done, 1'b0);
      @(negedge clk);
      cyc = 0;
      while (q_idx.size() > 0 && cyc < 300) begin
         idx = q_idx[0];
         chk("valid", out_valid, 1'b1);
         chk("index", out_index, idx);
         chk("word", out_word, mem[idx]);
         chk("mismatch", out_mismatch, model_mism(mem[idx]));
         chk("read_pointer", read_pointer, (idx + 1) % 32);
         chk("mcount", mismatch_count, exp_mc);
         case (mode)
            1:       rdy = 1'($urandom_range(0, 1));
            2:       rdy = !(cyc >= 1 && cyc <= 5);
            default: rdy = 1'b1;
         endcase
         out_ready = rdy;
         start     = (mode == 2 && cyc == 2);
         first_ptr = 5'd17;
         count     = CNT_W'(5);
         @(negedge clk);
         start = 1'b0;
         if (rdy) begin
            if (model_mism(mem[idx]) && exp_mc < 16'hFFFF) exp_mc++;
            void'(q_idx.pop_front());
         end
         cyc++;
      end
      chk("burst_budget", q_idx.size(), 0);
      chk("done_after_last", done, 1'b1);
      chk("valid_cleared", out_valid, 1'b0);
      chk("mcount_end", mismatch_count, exp_mc);
      out_ready = 1'b0;
      @(negedge clk);
      chk("done_pulse", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_valid", out_valid, 1'b0);
   endtask

   initial begin
      checks = 0; passes = 0; fails = 0; exp_mc = 0;
      reset = 1'b1; start = 1'b0; first_ptr = 5'd0; count = '0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = rand_entry();

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_word", out_word, 132'd0);
      chk("rst_index", out_index, 5'd0);
      chk("rst_mism", out_mismatch, 1'b0);
      chk("rst_mcount", mismatch_count, 16'd0);
      chk("rst_rdptr", read_pointer, 5'd0);
      reset = 1'b0;

      // basic burst, then wrap across 31, then a mid-burst stall
      burst(4, 3, 0);
      burst(30, 4, 0);
      burst(8, 6, 2);

      // known-good ADD entry, then the same entry with a wrong result
      mem[10].opcode = ADD; mem[10].operand_a = -32'sd1; mem[10].operand_b = 32'sd1;
      mem[10].result = 64'sd0;
      burst(10, 1, 0);
      chk("add_ok_mcount", mismatch_count, 16'd0);
      mem[10].result = 64'sd5;
      burst(10, 1, 0);
      chk("add_bad_mcount", mismatch_count, 16'd1);

      // divide / modulo by zero are never flagged
      mem[20].opcode = DIV; mem[20].operand_a = 32'sd7; mem[20].operand_b = 32'sd0;
      mem[20].result = 64'sd123;
      mem[21].opcode = MOD; mem[21].operand_a = -32'sd9; mem[21].operand_b = 32'sd0;
      mem[21].result = -64'sd4;
      burst(20, 2, 0);

      // empty burst
      burst(5, 0, 0);

      // random bursts over partly corrupted contents, including full 32-entry sweeps
      for (int i = 0; i < 32; i++) begin
         mem[i] = rand_entry();
         if ($urandom_range(0, 3) == 0) mem[i].result = mem[i].result ^ 64'sd1;
      end
      for (int k = 0; k < 5; k++) burst($urandom_range(0, 31), $urandom_range(1, 32), 1);
      burst($urandom_range(0, 31), 32, 1);
      burst($urandom_range(0, 31), 32, 0);

      // reset in the middle of a burst while out_valid is high
      start = 1'b1; first_ptr = 5'd3; count = CNT_W'(5); out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", out_valid, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_valid", out_valid, 1'b0);
      chk("async_busy", busy, 1'b0);
      chk("async_mcount", mismatch_count, 16'd0);
      chk("async_rdptr", read_pointer, 5'd0);
      exp_mc = 0;
      @(negedge clk);
      chk("rst_no_done", done, 1'b0);
      reset = 1'b0;
      burst(12, 2, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
